uart_rx: RTL and testbench

Serial receiver that pairs with the team's UART transmitter. It takes an 8N1-style line clocked at `CLOCKS_PER_PULSE` system clocks per bit and reassembles `NUM_WORDS` consecutive characters into one `W_OUT`-bit word, least-significant byte first. The word is presented on a valid/ready stream interface toward the core. It sits at the chip pin boundary, opposite the transmitter.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_sync2.sv | 31 +++
 rtl/uart_rx.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_pkg
// Brief   : Shared UART definitions (RX state encoding, frame geometry helpers)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Characters needed to carry one output word.
    function automatic int num_words(input int w_out, input int bits_per_word);
        return (w_out + bits_per_word - 1) / bits_per_word;
    endfunction

    // Line bits per character: start + data + stop.
    function automatic int total_bits(input int bits_per_word, input int stop_bits);
        return 1 + bits_per_word + stop_bits;
    endfunction

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_if
// Brief   : Valid/ready word stream from the UART receiver toward the core
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_rx_if #(
    parameter int W_OUT = 24
);
    logic [W_OUT-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

`default_nettype wire

// File: rtl/uart_sync2.sv
//------------------------------------------------------------------------------
// Module  : uart_sync2
// Brief   : Two-flop synchronizer for an asynchronous input, reset to RESET_VAL
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rstn,
    input  wire logic d,
    output logic      q
);

    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// Module  : uart_rx
// Brief   : 8N1-style serial receiver assembling NUM_WORDS characters per word
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_OUT            = 24,
    parameter int STOP_BITS        = 1
) (
    input  wire logic   clk,
    input  wire logic   rstn,
    input  wire logic   rx,
    uart_rx_if.master   m,
    output logic        frame_err,
    output logic        overflow
);

    localparam int NUM_WORDS = num_words(W_OUT, BITS_PER_WORD);
    localparam int HALF      = CLOCKS_PER_PULSE / 2;
    localparam int CW        = cnt_width(CLOCKS_PER_PULSE);
    localparam int BW        = cnt_width(BITS_PER_WORD);
    localparam int SW        = cnt_width(STOP_BITS);
    localparam int WW        = cnt_width(NUM_WORDS);
    localparam int ASM_W     = NUM_WORDS * BITS_PER_WORD;

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_WORD - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

    logic                     rxs;
    rx_state_t                state, state_nxt;
    logic [CW-1:0]            clk_cnt, clk_cnt_nxt;
    logic [BW-1:0]            bit_cnt, bit_cnt_nxt;
    logic [SW-1:0]            stop_cnt, stop_cnt_nxt;
    logic                     brk, brk_nxt;
    logic                     data_smp, char_ok, char_bad, mid;
    logic [WW-1:0]            word_cnt;
    logic [BITS_PER_WORD-1:0] shift;
    logic [ASM_W-1:0]         assembly, assembly_nxt;
    logic [W_OUT-1:0]         out_data;
    logic                     out_valid;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rx),
        .q    (rxs)
    );

    assign mid = (clk_cnt == CLK_LAST);

    always_comb begin
        state_nxt    = state;
        clk_cnt_nxt  = clk_cnt;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        brk_nxt      = brk;
        data_smp     = 1'b0;
        char_ok      = 1'b0;
        char_bad     = 1'b0;
        case (state)
            RX_IDLE: begin
                clk_cnt_nxt  = '0;
                bit_cnt_nxt  = '0;
                stop_cnt_nxt = '0;
                brk_nxt      = 1'b0;
                if (!rxs) state_nxt = RX_START;
            end
            RX_START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = rxs ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + CW'(1);
                end
            end
            RX_DATA: begin
                if (mid) begin
                    clk_cnt_nxt = '0;
                    data_smp    = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_nxt  = '0;
                        stop_cnt_nxt = '0;
                        state_nxt    = RX_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CW'(1);
                end
            end
            RX_STOP: begin
                // After a bad stop bit, hold here until the line is released
                // so a break condition is not taken as a new start bit.
                if (brk) begin
                    if (rxs) state_nxt = RX_IDLE;
                end else if (mid) begin
                    clk_cnt_nxt = '0;
                    if (!rxs) begin
                        char_bad = 1'b1;
                        brk_nxt  = 1'b1;
                    end else if (stop_cnt == STOP_LAST) begin
                        char_ok      = 1'b1;
                        stop_cnt_nxt = '0;
                        state_nxt    = RX_IDLE;
                    end else begin
                        stop_cnt_nxt = stop_cnt + SW'(1);
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CW'(1);
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        assembly_nxt = assembly;
        assembly_nxt[word_cnt * BITS_PER_WORD +: BITS_PER_WORD] = shift;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= RX_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            brk      <= 1'b0;
        end else begin
            state    <= state_nxt;
            clk_cnt  <= clk_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            stop_cnt <= stop_cnt_nxt;
            brk      <= brk_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift     <= '0;
            assembly  <= '0;
            word_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= char_bad;
            overflow  <= 1'b0;
            if (data_smp) shift[bit_cnt] <= rxs;
            if (out_valid && m.m_ready) out_valid <= 1'b0;
            if (char_bad) word_cnt <= '0;
            if (char_ok) begin
                assembly <= assembly_nxt;
                if (word_cnt == WORD_LAST) begin
                    word_cnt <= '0;
                    // Accept the new word only if the slot is free or is being
                    // emptied this very cycle; otherwise it is dropped.
                    if (!out_valid || m.m_ready) begin
                        out_data  <= assembly_nxt[W_OUT-1:0];
                        out_valid <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    word_cnt <= word_cnt + WW'(1);
                end
            end
        end
    end

    assign m.m_data  = out_data;
    assign m.m_valid = out_valid;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_rx
// Brief   : Directed self-checking bench for uart_rx
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

    localparam int CPP = 4;
    localparam int W   = 24;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rx = 1'b1;
    logic frame_err, overflow;

    uart_rx_if #(.W_OUT(W)) bus ();

    uart_rx #(
        .CLOCKS_PER_PULSE (CPP),
        .BITS_PER_WORD    (8),
        .W_OUT            (W),
        .STOP_BITS        (1)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .m         (bus),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_ferr = 0;
    int n_ovf = 0;
    logic [W-1:0] got[$];

    always @(negedge clk) begin
        if (frame_err) n_ferr++;
        if (overflow) n_ovf++;
        if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // All line drivers are entered and left #1 after a rising edge.
    task automatic send_char(input logic [7:0] c, input logic stop);
        rx = 1'b0;
        repeat (CPP) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = c[i];
            repeat (CPP) @(posedge clk);
            #1;
        end
        rx = stop;
        repeat (CPP) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        send_char(w[7:0], 1'b1);
        send_char(w[15:8], 1'b1);
        send_char(w[23:16], 1'b1);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept_word(input logic [W-1:0] exp);
        int k;
        k = 0;
        while (!bus.m_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        if (bus.m_valid !== 1'b1) begin
            bad++;
            $display("FAIL accept_valid: m_valid=%b want 1", bus.m_valid);
        end
        total++;
        if (bus.m_data !== exp) begin
            bad++;
            $display("FAIL accept_data: m_data=%06h want %06h", bus.m_data, exp);
        end
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        total++;
        if (bus.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL accept_clear: m_valid=%b want 0", bus.m_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.m_valid, frame_err, overflow} !== 3'b000 || bus.m_data !== 24'h0) begin
            bad++;
            $display("FAIL reset_out: valid/ferr/ovf=%b%b%b data=%06h want 000 000000",
                     bus.m_valid, frame_err, overflow, bus.m_data);
        end
        rstn = 1'b1;
        idle(4);
    endtask

    task automatic test_basic();
        send_char(8'hF0, 1'b1);
        send_char(8'hC3, 1'b1);
        send_char(8'hA5, 1'b1);
        total++;
        if (bus.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early: m_valid=%b want 0 before final stop sample", bus.m_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 24'hA5C3F0) begin
            bad++;
            $display("FAIL basic_word: valid=%b data=%06h want 1 a5c3f0", bus.m_valid, bus.m_data);
        end
        idle(6);
        total++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 24'hA5C3F0) begin
            bad++;
            $display("FAIL basic_hold: valid=%b data=%06h want 1 a5c3f0", bus.m_valid, bus.m_data);
        end
        accept_word(24'hA5C3F0);
    endtask

    task automatic test_glitch();
        int f0;
        f0 = n_ferr;
        rx = 1'b0;
        @(posedge clk);
        #1;
        idle(20);
        total++;
        if (bus.m_valid !== 1'b0 || n_ferr != f0) begin
            bad++;
            $display("FAIL glitch: valid=%b ferr_pulses=%0d want 0 0", bus.m_valid, n_ferr - f0);
        end
        send_word(24'h123456);
        accept_word(24'h123456);
    endtask

    task automatic test_frame_err();
        int f0;
        f0 = n_ferr;
        send_char(8'h5A, 1'b1);
        send_char(8'h77, 1'b0);
        // Hold the line low as a break before releasing it.
        repeat (20) @(posedge clk);
        #1;
        idle(10);
        total++;
        if (n_ferr - f0 != 1) begin
            bad++;
            $display("FAIL frame_err_pulse: cycles=%0d want 1", n_ferr - f0);
        end
        total++;
        if (bus.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL frame_err_valid: m_valid=%b want 0", bus.m_valid);
        end
        send_word(24'h332211);
        accept_word(24'h332211);
    endtask

    task automatic test_backpressure();
        int o0;
        o0 = n_ovf;
        send_word(24'hABCDEF);
        idle(2);
        total++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 24'hABCDEF) begin
            bad++;
            $display("FAIL bp_first: valid=%b data=%06h want 1 abcdef", bus.m_valid, bus.m_data);
        end
        send_word(24'h135724);
        idle(3);
        total++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 24'hABCDEF) begin
            bad++;
            $display("FAIL bp_held: valid=%b data=%06h want 1 abcdef", bus.m_valid, bus.m_data);
        end
        total++;
        if (n_ovf - o0 != 1) begin
            bad++;
            $display("FAIL bp_overflow: cycles=%0d want 1", n_ovf - o0);
        end
        // Ready only in the completion cycle of the next word.
        o0 = n_ovf;
        send_char(8'h0D, 1'b1);
        send_char(8'hF0, 1'b1);
        fork
            send_char(8'h9E, 1'b1);
            begin
                repeat (CPP * 10) @(posedge clk);
                #1;
                bus.m_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.m_ready = 1'b0;
            end
        join
        idle(2);
        total++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 24'h9EF00D) begin
            bad++;
            $display("FAIL bp_same_cycle: valid=%b data=%06h want 1 9ef00d", bus.m_valid, bus.m_data);
        end
        total++;
        if (n_ovf != o0) begin
            bad++;
            $display("FAIL bp_no_overflow: cycles=%0d want 0", n_ovf - o0);
        end
        accept_word(24'h9EF00D);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] sent[20];
        int base, f0, o0;
        base = got.size();
        f0 = n_ferr;
        o0 = n_ovf;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sent[i] = W'($urandom);
            send_word(sent[i]);
        end
        idle(10);
        bus.m_ready = 1'b0;
        total++;
        if (got.size() - base != 20 || n_ferr != f0 || n_ovf != o0) begin
            bad++;
            $display("FAIL stream_count: words=%0d ferr=%0d ovf=%0d want 20 0 0",
                     got.size() - base, n_ferr - f0, n_ovf - o0);
        end
        for (int i = 0; i < 20; i++) begin
            if (base + i < got.size()) begin
                total++;
                if (got[base + i] !== sent[i]) begin
                    bad++;
                    $display("FAIL stream_word[%0d]: got %06h want %06h", i, got[base + i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] c2;
        c2 = 8'h02;
        send_word(24'h0A0B0C);
        idle(2);
        send_char(8'h03, 1'b1);
        rx = 1'b0;
        repeat (CPP) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            rx = c2[i];
            repeat ((i == 4) ? 2 : CPP) @(posedge clk);
            #1;
        end
        rstn = 1'b0;
        #1;
        total++;
        if ({bus.m_valid, frame_err, overflow} !== 3'b000 || bus.m_data !== 24'h0) begin
            bad++;
            $display("FAIL reset_mid_out: valid/ferr/ovf=%b%b%b data=%06h want 000 000000",
                     bus.m_valid, frame_err, overflow, bus.m_data);
        end
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(5);
        send_word(24'h010203);
        accept_word(24'h010203);
    endtask

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
